// File: rtl/vga_layer_mixer.sv
// VGA output stage: priority-merges NL graphic layers over a background colour, with blanking,
// per-layer frame blinking and a colour-bar test pattern, then delays colour and syncs by PIPE ticks.
module vga_layer_mixer #(
  parameter int CW         = 4,
  parameter int NL         = 4,
  parameter int PIPE       = 2,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pixel_tick,
  input  logic                 video_on,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  input  logic [NL-1:0]        layer_on,
  input  logic [NL*3*CW-1:0]   layer_rgb,
  input  logic [NL-1:0]        layer_blink,
  input  logic [3*CW-1:0]      bg_rgb,
  input  logic                 test_mode,
  output logic                 Hsync,
  output logic                 Vsync,
  output logic [CW-1:0]        vgaRed,
  output logic [CW-1:0]        vgaGreen,
  output logic [CW-1:0]        vgaBlue,
  output logic [15:0]          frame_count
);

  localparam int PW = 3 * CW;

  logic            vsyncPrev_q;
  logic [15:0]     frameCount_q, frameCount_d;
  logic [10:0]     column_q, column_d;
  logic            hide;
  logic [2:0]      bar;
  logic [PW-1:0]   layerColour, barColour, pixel_d;
  logic [PW-1:0]   rgbPipe_q [PIPE];
  logic [PIPE-1:0] hsPipe_q, vsPipe_q;

  // Blink phase comes from the registered counter, so a vsync edge on this tick
  // only affects the next pixel's decision.
  always_comb begin
    hide        = frameCount_q[BLINK_LOG2];
    layerColour = bg_rgb;
    for (int i = NL - 1; i >= 0; i--) begin
      if (layer_on[i] && !(layer_blink[i] && hide)) begin
        layerColour = layer_rgb[i*PW +: PW];
      end
    end
  end

  always_comb begin
    bar       = column_q[9:7];
    barColour = {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}};
    pixel_d   = '0;
    if (video_on) begin
      pixel_d = test_mode ? barColour : layerColour;
    end
    frameCount_d = (vsyncPrev_q && !vsync_in) ? frameCount_q + 16'd1 : frameCount_q;
    column_d     = video_on ? column_q + 11'd1 : 11'd0;
  end

  // Syncs travel through the same number of stages as colour to stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsyncPrev_q  <= 1'b1;
      frameCount_q <= '0;
      column_q     <= '0;
      hsPipe_q     <= '1;
      vsPipe_q     <= '1;
      for (int s = 0; s < PIPE; s++) begin
        rgbPipe_q[s] <= '0;
      end
    end else if (pixel_tick) begin
      vsyncPrev_q  <= vsync_in;
      frameCount_q <= frameCount_d;
      column_q     <= column_d;
      rgbPipe_q[0] <= pixel_d;
      hsPipe_q[0]  <= hsync_in;
      vsPipe_q[0]  <= vsync_in;
      for (int s = 1; s < PIPE; s++) begin
        rgbPipe_q[s] <= rgbPipe_q[s-1];
        hsPipe_q[s]  <= hsPipe_q[s-1];
        vsPipe_q[s]  <= vsPipe_q[s-1];
      end
    end
  end

  assign Hsync       = hsPipe_q[PIPE-1];
  assign Vsync       = vsPipe_q[PIPE-1];
  assign vgaRed      = rgbPipe_q[PIPE-1][PW-1 -: CW];
  assign vgaGreen    = rgbPipe_q[PIPE-1][2*CW-1 -: CW];
  assign vgaBlue     = rgbPipe_q[PIPE-1][CW-1:0];
  assign frame_count = frameCount_q;

endmodule

// File: tb/tb_vga_layer_mixer.sv
// Bench for vga_layer_mixer: directed steps plus randomized pixels, checked against a
// pixel-history reference model of the mixer's behaviour.
module tb_vga_layer_mixer;

  localparam int CW   = 4;
  localparam int NL   = 4;
  localparam int PIPE = 3;
  localparam int BL   = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          pixelTick;
  logic          vidOn;
  logic          hsIn;
  logic          vsIn;
  logic [NL-1:0] layOn;
  logic [47:0]   layRgb;
  logic [NL-1:0] layBlink;
  logic [11:0]   bg;
  logic          testMode;
  logic          Hsync, Vsync;
  logic [3:0]    vgaRed, vgaGreen, vgaBlue;
  logic [15:0]   frameCount;

  int testsRun  = 0;
  int failCount = 0;

  // Reference model state: frame number, last vsync, column, and pixels in flight.
  int          mFrame;
  logic        mVsPrev;
  int          mCol;
  logic [13:0] hist [$];
  logic [11:0] barTab [5];

  vga_layer_mixer #(.CW(CW), .NL(NL), .PIPE(PIPE), .BLINK_LOG2(BL)) dut (
    .clk        (clk),
    .reset      (reset),
    .pixel_tick (pixelTick),
    .video_on   (vidOn),
    .hsync_in   (hsIn),
    .vsync_in   (vsIn),
    .layer_on   (layOn),
    .layer_rgb  (layRgb),
    .layer_blink(layBlink),
    .bg_rgb     (bg),
    .test_mode  (testMode),
    .Hsync      (Hsync),
    .Vsync      (Vsync),
    .vgaRed     (vgaRed),
    .vgaGreen   (vgaGreen),
    .vgaBlue    (vgaBlue),
    .frame_count(frameCount)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mFrame  = 0;
    mVsPrev = 1'b1;
    mCol    = 0;
    hist.delete();
  endtask

  // Compute what the pixel presented on this tick should look like, then advance counters.
  task automatic modelStep();
    int          hide;
    int          b;
    bit          found;
    logic [11:0] c;
    hide  = (mFrame >> BL) & 1;
    c     = 12'h000;
    found = 1'b0;
    if (!vidOn) begin
      c = 12'h000;
    end else if (testMode) begin
      b = (mCol / 128) % 8;
      c = {((b & 4) != 0) ? 4'hF : 4'h0, ((b & 2) != 0) ? 4'hF : 4'h0, ((b & 1) != 0) ? 4'hF : 4'h0};
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (!found && layOn[i] && !(layBlink[i] && hide == 1)) begin
          c     = layRgb[i*12 +: 12];
          found = 1'b1;
        end
      end
      if (!found) c = bg;
    end
    hist.push_back({hsIn, vsIn, c});
    if (hist.size() > PIPE) void'(hist.pop_front());
    if (mVsPrev && !vsIn) mFrame = (mFrame + 1) % 65536;
    mVsPrev = vsIn;
    mCol    = vidOn ? (mCol + 1) % 2048 : 0;
  endtask

  task automatic checkOutput(input string tag);
    logic [13:0] exp;
    exp = (hist.size() == PIPE) ? hist[0] : 14'h3000;
    cmp({tag, ".rgb"},   16'({vgaRed, vgaGreen, vgaBlue}), 16'(exp[11:0]));
    cmp({tag, ".hsync"}, 16'(Hsync), 16'(exp[13]));
    cmp({tag, ".vsync"}, 16'(Vsync), 16'(exp[12]));
    cmp({tag, ".frame"}, frameCount, 16'(mFrame));
  endtask

  task automatic checkColour(input string tag, input logic [11:0] exp);
    cmp(tag, 16'({vgaRed, vgaGreen, vgaBlue}), 16'(exp));
  endtask

  // Idle clocks (pixel_tick low) must leave everything unchanged, then one tick is applied.
  task automatic applyStimulus(input int idle, input string tag);
    repeat (idle) begin
      @(negedge clk);
      pixelTick = 1'b0;
      @(posedge clk);
      #1;
      checkOutput({tag, ".hold"});
    end
    @(negedge clk);
    pixelTick = 1'b1;
    @(posedge clk);
    #1;
    modelStep();
    checkOutput(tag);
    pixelTick = 1'b0;
  endtask

  initial begin
    int pixOut;
    barTab = '{12'h000, 12'h00F, 12'h0F0, 12'h0FF, 12'hF00};
    reset = 1'b1;
    pixelTick = 1'b0;
    vidOn = 1'b0; hsIn = 1'b1; vsIn = 1'b1; testMode = 1'b0;
    layOn = '0; layRgb = '0; layBlink = '0; bg = '0;
    modelReset();

    // Reset held with random inputs toggling
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pixelTick = 1'($urandom); vidOn = 1'($urandom); hsIn = 1'($urandom); vsIn = 1'($urandom);
      layOn = 4'($urandom); layRgb = {16'($urandom), $urandom}; bg = 12'($urandom);
      @(posedge clk);
      #1;
      checkOutput("reset_hold");
    end

    // Release reset; background only, one tick every 4 clocks
    @(negedge clk);
    reset = 1'b0; pixelTick = 1'b0;
    vidOn = 1'b1; hsIn = 1'b1; vsIn = 1'b1; testMode = 1'b0;
    layOn = '0; layBlink = '0; bg = 12'h1A3;
    for (int k = 0; k <= PIPE + 1; k++) begin
      applyStimulus(3, "bg_fill");
      if (k < PIPE - 1) checkColour("bg_before_latency", 12'h000);
      else              checkColour("bg_latency", 12'h1A3);
    end

    // Priority between layers
    layOn = 4'b1010; layRgb[12 +: 12] = 12'hF00; layRgb[36 +: 12] = 12'h0F0;
    repeat (PIPE) applyStimulus(0, "prio_1010");
    checkColour("prio_1010_val", 12'hF00);
    layOn = 4'b1000;
    repeat (PIPE) applyStimulus(1, "prio_1000");
    checkColour("prio_1000_val", 12'h0F0);
    vidOn = 1'b0;
    repeat (PIPE) applyStimulus(0, "blank");
    checkColour("blank_val", 12'h000);

    // Blink: layer 0 blinking over layer 1 across 4 frames
    vidOn = 1'b1; layOn = 4'b0011; layBlink = 4'b0001;
    layRgb[0 +: 12] = 12'h0FF; layRgb[12 +: 12] = 12'hF0F;
    for (int f = 0; f < 4; f++) begin
      repeat (PIPE) applyStimulus(0, "blink");
      checkColour("blink_frame", (f < 2) ? 12'h0FF : 12'hF0F);
      vsIn = 1'b0;
      applyStimulus(0, "blink_vs_low");
      vsIn = 1'b1;
      applyStimulus(0, "blink_vs_high");
    end
    cmp("frame_count_4", frameCount, 16'd4);

    // Sync alignment: a one-tick hsync pulse carrying a marker colour
    layOn = '0; layBlink = '0; bg = 12'h000;
    repeat (PIPE) applyStimulus(0, "sync_pre");
    hsIn = 1'b0; bg = 12'h5A5;
    applyStimulus(0, "sync_pulse");
    hsIn = 1'b1; bg = 12'h000;
    for (int t = 1; t <= PIPE; t++) begin
      applyStimulus(0, "sync_post");
      if (t == PIPE - 1) begin
        cmp("hsync_aligned", 16'(Hsync), 16'd0);
        checkColour("hsync_colour", 12'h5A5);
      end else begin
        cmp("hsync_idle", 16'(Hsync), 16'd1);
      end
    end

    // Test pattern across a 640-pixel line, then column clear on blanking
    testMode = 1'b1; vidOn = 1'b0;
    applyStimulus(0, "bars_clear");
    vidOn = 1'b1;
    for (int c = 0; c < 640; c++) begin
      applyStimulus(0, "bars");
      pixOut = c - (PIPE - 1);
      if (pixOut >= 0 && pixOut % 128 == 0) checkColour("bar_colour", barTab[pixOut / 128]);
    end
    vidOn = 1'b0;
    repeat (4) applyStimulus(0, "bars_blank");
    vidOn = 1'b1;
    repeat (PIPE) applyStimulus(0, "bars_restart");
    checkColour("bars_column_cleared", 12'h000);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      vidOn    = ($urandom_range(0, 7) != 0);
      hsIn     = ($urandom_range(0, 5) != 0);
      vsIn     = ($urandom_range(0, 11) != 0);
      testMode = ($urandom_range(0, 3) == 0);
      layOn    = 4'($urandom);
      layBlink = 4'($urandom);
      layRgb   = {16'($urandom), $urandom};
      bg       = 12'($urandom);
      applyStimulus($urandom_range(0, 2), "random");
    end

    // Asynchronous reset between ticks, then refill
    testMode = 1'b0; vidOn = 1'b1; hsIn = 1'b1; vsIn = 1'b1; layOn = '0; bg = 12'h3C5;
    repeat (PIPE + 1) applyStimulus(0, "pre_async");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("async_reset");
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k <= PIPE; k++) begin
      applyStimulus(1, "refill");
      if (k < PIPE - 1) checkColour("refill_empty", 12'h000);
      else              checkColour("refill_val", 12'h3C5);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
